// File: rtl/riscv_bus_arbiter.sv
// Round-robin arbiter sharing the ROM/RAM/UART bus between the icache
// reload port and the dcache port, one transaction at a time.
module riscv_bus_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] UART_BASE   = 32'hC000_0000,
    parameter logic [31:0] RAM_BASE    = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        icache_bus_access_request,
    input  logic [31:0] icache_raddr,
    output logic        icache_bus_access_accept,
    output logic [63:0] icache_rdata,
    input  logic        dcache_bus_access_request,
    input  logic        dcache_ren,
    input  logic [3:0]  dcache_wen,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_wdata,
    output logic        dcache_bus_access_accept,
    output logic [31:0] dcache_rdata,
    output logic [31:0] rom_raddr,
    input  logic [63:0] rom_rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [3:0]  ram_wen,
    output logic        ram_ren,
    output logic [31:0] uart_addr,
    output logic [31:0] uart_data_in,
    input  logic [31:0] uart_data_out,
    output logic        uart_configure
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    localparam logic [2:0] WAIT_CYCLES = 3'(MEM_LATENCY - 1);
    localparam logic       GNT_I       = 1'b0;
    localparam logic       GNT_D       = 1'b1;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        rd_q, rd_d;
    logic        uart_q, uart_d;
    logic [3:0]  wen_q, wen_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rom_raddr_q, rom_raddr_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [31:0] uart_addr_q, uart_addr_d;
    logic [31:0] uart_wdata_q, uart_wdata_d;
    logic [63:0] ic_rdata_q, ic_rdata_d;
    logic [31:0] dc_rdata_q, dc_rdata_d;

    logic dc_wr;
    logic dc_rd;
    logic to_uart;
    logic issue;

    // Write wins over read; no strobes at all is a read.
    assign dc_wr   = |dcache_wen;
    assign dc_rd   = dcache_ren | ~dc_wr;
    // RAM region has priority should the two bases ever coincide.
    assign to_uart = (dcache_addr[31:28] == UART_BASE[31:28]) &&
                     (dcache_addr[31:28] != RAM_BASE[31:28]);

    // Next-state, request capture and read-data capture.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        rd_d         = rd_q;
        uart_d       = uart_q;
        wen_d        = wen_q;
        cnt_d        = cnt_q;
        rom_raddr_d  = rom_raddr_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        uart_addr_d  = uart_addr_q;
        uart_wdata_d = uart_wdata_q;
        ic_rdata_d   = ic_rdata_q;
        dc_rdata_d   = dc_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (icache_bus_access_request || dcache_bus_access_request) begin
                    if (icache_bus_access_request && dcache_bus_access_request) begin
                        gnt_d = ~last_q;
                    end else begin
                        gnt_d = dcache_bus_access_request;
                    end
                    if (gnt_d == GNT_I) begin
                        rd_d        = 1'b1;
                        uart_d      = 1'b0;
                        wen_d       = 4'b0000;
                        rom_raddr_d = icache_raddr;
                    end else begin
                        rd_d   = dc_rd & ~dc_wr;
                        uart_d = to_uart;
                        wen_d  = dcache_wen;
                        if (to_uart) begin
                            uart_addr_d  = dcache_addr;
                            uart_wdata_d = dcache_wdata;
                        end else begin
                            ram_addr_d  = dcache_addr;
                            ram_wdata_d = dcache_wdata;
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = WAIT_CYCLES;
                if (!rd_q) begin
                    state_d = DONE;
                end else if (gnt_q && uart_q) begin
                    dc_rdata_d = uart_data_out;
                    state_d    = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (gnt_q == GNT_D) begin
                        dc_rdata_d = ram_rdata;
                    end else begin
                        ic_rdata_d = rom_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_I;
            last_q       <= GNT_D;
            rd_q         <= 1'b0;
            uart_q       <= 1'b0;
            wen_q        <= 4'b0000;
            cnt_q        <= 3'd0;
            rom_raddr_q  <= 32'd0;
            ram_addr_q   <= 32'd0;
            ram_wdata_q  <= 32'd0;
            uart_addr_q  <= 32'd0;
            uart_wdata_q <= 32'd0;
            ic_rdata_q   <= 64'd0;
            dc_rdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            rd_q         <= rd_d;
            uart_q       <= uart_d;
            wen_q        <= wen_d;
            cnt_q        <= cnt_d;
            rom_raddr_q  <= rom_raddr_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            uart_addr_q  <= uart_addr_d;
            uart_wdata_q <= uart_wdata_d;
            ic_rdata_q   <= ic_rdata_d;
            dc_rdata_q   <= dc_rdata_d;
        end
    end

    assign issue = (state_q == ISSUE);

    assign ram_ren        = issue & gnt_q & ~uart_q & rd_q;
    assign ram_wen        = (issue & gnt_q & ~uart_q & ~rd_q) ? wen_q : 4'b0000;
    assign uart_configure = issue & gnt_q & uart_q & ~rd_q;

    assign icache_bus_access_accept = (state_q == DONE) && (gnt_q == GNT_I);
    assign dcache_bus_access_accept = (state_q == DONE) && (gnt_q == GNT_D);

    assign rom_raddr    = rom_raddr_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign uart_addr    = uart_addr_q;
    assign uart_data_in = uart_wdata_q;
    assign icache_rdata = ic_rdata_q;
    assign dcache_rdata = dc_rdata_q;

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Bench for riscv_bus_arbiter: ROM/RAM/UART models, expected-accept
// scoreboard, latency and strobe checks, plus a MEM_LATENCY=4 instance.
module tb_riscv_bus_arbiter;

    typedef struct {
        logic        is_d;
        logic        chk;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        srst_n;
    logic        ic_req;
    logic [31:0] ic_raddr;
    logic        ic_acc;
    logic [63:0] ic_rdata;
    logic        dc_req;
    logic        dc_ren;
    logic [3:0]  dc_wen;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_acc;
    logic [31:0] dc_rdata;
    logic [31:0] rom_raddr;
    logic [63:0] rom_rdata;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [3:0]  ram_wen;
    logic        ram_ren;
    logic [31:0] uart_addr;
    logic [31:0] uart_data_in;
    logic [31:0] uart_data_out;
    logic        uart_configure;

    logic        ic_req4;
    logic [31:0] ic_raddr4;
    logic        ic_acc4;
    logic [63:0] ic_rdata4;
    logic        dc_req4;
    logic        dc_ren4;
    logic [3:0]  dc_wen4;
    logic [31:0] dc_addr4;
    logic [31:0] dc_wdata4;
    logic        dc_acc4;
    logic [31:0] dc_rdata4;
    logic [31:0] rom_raddr4;
    logic [63:0] rom_rdata4;
    logic [31:0] ram_addr4;
    logic [31:0] ram_wdata4;
    logic [31:0] ram_rdata4;
    logic [3:0]  ram_wen4;
    logic        ram_ren4;
    logic [31:0] uart_addr4;
    logic [31:0] uart_data_in4;
    logic [31:0] uart_data_out4;
    logic        uart_configure4;

    logic [31:0] ram_mem [16];

    int checks;
    int errors;
    exp_t sbq[$];
    exp_t e;
    int n, rc, wc, cc;
    logic wd;
    logic [3:0] wv;
    logic [31:0] cv, ra;

    riscv_bus_arbiter #(.MEM_LATENCY(1)) dut (
        .clk                       (clk),
        .srst_n                    (srst_n),
        .icache_bus_access_request (ic_req),
        .icache_raddr              (ic_raddr),
        .icache_bus_access_accept  (ic_acc),
        .icache_rdata              (ic_rdata),
        .dcache_bus_access_request (dc_req),
        .dcache_ren                (dc_ren),
        .dcache_wen                (dc_wen),
        .dcache_addr               (dc_addr),
        .dcache_wdata              (dc_wdata),
        .dcache_bus_access_accept  (dc_acc),
        .dcache_rdata              (dc_rdata),
        .rom_raddr                 (rom_raddr),
        .rom_rdata                 (rom_rdata),
        .ram_addr                  (ram_addr),
        .ram_wdata                 (ram_wdata),
        .ram_rdata                 (ram_rdata),
        .ram_wen                   (ram_wen),
        .ram_ren                   (ram_ren),
        .uart_addr                 (uart_addr),
        .uart_data_in              (uart_data_in),
        .uart_data_out             (uart_data_out),
        .uart_configure            (uart_configure)
    );

    riscv_bus_arbiter #(.MEM_LATENCY(4)) dut4 (
        .clk                       (clk),
        .srst_n                    (srst_n),
        .icache_bus_access_request (ic_req4),
        .icache_raddr              (ic_raddr4),
        .icache_bus_access_accept  (ic_acc4),
        .icache_rdata              (ic_rdata4),
        .dcache_bus_access_request (dc_req4),
        .dcache_ren                (dc_ren4),
        .dcache_wen                (dc_wen4),
        .dcache_addr               (dc_addr4),
        .dcache_wdata              (dc_wdata4),
        .dcache_bus_access_accept  (dc_acc4),
        .dcache_rdata              (dc_rdata4),
        .rom_raddr                 (rom_raddr4),
        .rom_rdata                 (rom_rdata4),
        .ram_addr                  (ram_addr4),
        .ram_wdata                 (ram_wdata4),
        .ram_rdata                 (ram_rdata4),
        .ram_wen                   (ram_wen4),
        .ram_ren                   (ram_ren4),
        .uart_addr                 (uart_addr4),
        .uart_data_in              (uart_data_in4),
        .uart_data_out             (uart_data_out4),
        .uart_configure            (uart_configure4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_rdata = (rom_raddr == 32'h40) ? 64'hDEAD_BEEF_0123_4567
                                             : {~rom_raddr, rom_raddr};
    assign ram_rdata     = ram_mem[ram_addr[5:2]];
    assign uart_data_out = 32'h5AA5_0000 | {16'h0, uart_addr[15:0]};

    assign rom_rdata4     = 64'd0;
    assign ram_rdata4     = 32'h4444_0000 | {16'h0, ram_addr4[15:0]};
    assign uart_data_out4 = 32'd0;

    always @(posedge clk) begin
        if (!srst_n) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 32'hA5A5_0000 | i;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) ram_mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic wait_acc(output int nn, output logic was_d,
                            output int ren_c, output int wen_c, output int cfg_c,
                            output logic [3:0] wen_v, output logic [31:0] cfg_v,
                            output logic [31:0] rom_a1);
        nn = -1; was_d = 1'b0; ren_c = 0; wen_c = 0; cfg_c = 0;
        wen_v = 4'b0; cfg_v = 32'd0; rom_a1 = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ram_ren) ren_c++;
            if (ram_wen != 4'b0) begin wen_c++; wen_v = ram_wen; end
            if (uart_configure) begin cfg_c++; cfg_v = uart_data_in; end
            if (i == 1) rom_a1 = rom_raddr;
            if (ic_acc || dc_acc) begin
                nn = i;
                was_d = dc_acc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        srst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 srst_n = 1'b1;
    endtask

    task automatic dc_start(input logic [31:0] a, input logic r,
                            input logic [3:0] w, input logic [31:0] d);
        @(posedge clk); #1;
        dc_addr = a; dc_ren = r; dc_wen = w; dc_wdata = d; dc_req = 1'b1;
    endtask

    task automatic dc_stop();
        @(posedge clk); #1;
        dc_req = 1'b0; dc_ren = 1'b0; dc_wen = 4'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({ic_acc, dc_acc, ram_ren, ram_wen, uart_configure} !== 8'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b, want 0",
                     {ic_acc, dc_acc, ram_ren, ram_wen, uart_configure});
        end
        checks++;
        if ({rom_raddr, ram_addr, ram_wdata, uart_addr, uart_data_in} !== 160'd0) begin
            errors++;
            $display("FAIL reset_addr: rom=%h ram=%h uart=%h, want 0",
                     rom_raddr, ram_addr, uart_addr);
        end
        checks++;
        if (ic_rdata !== 64'd0 || dc_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata: i=%h d=%h, want 0", ic_rdata, dc_rdata);
        end
    endtask

    task automatic test_icache_read();
        @(posedge clk); #1;
        ic_raddr = 32'h0000_0040; ic_req = 1'b1;
        sbq.push_back('{1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567});
        wait_acc(n, wd, rc, wc, cc, wv, cv, ra);
        @(posedge clk); #1 ic_req = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL icache_latency: got %0d, want 3", n);
        end
        checks++;
        if (ra !== 32'h40) begin
            errors++; $display("FAIL icache_rom_raddr: got %h, want 00000040", ra);
        end
        checks++;
        if (rc + wc + cc != 0) begin
            errors++; $display("FAIL icache_no_ram_uart: got %0d strobes, want 0", rc + wc + cc);
        end
        e = sbq.pop_front();
        checks++;
        if (n < 0 || wd !== e.is_d || ic_rdata !== e.data) begin
            errors++;
            $display("FAIL icache_data: who=%b data=%h, want who=%b data=%h",
                     wd, ic_rdata, e.is_d, e.data);
        end
    endtask

    task automatic test_dcache_write();
        dc_start(32'h8000_0010, 1'b0, 4'b0011, 32'h1234_5678);
        sbq.push_back('{1'b1, 1'b0, 64'd0});
        wait_acc(n, wd, rc, wc, cc, wv, cv, ra);
        dc_stop();
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL dwrite_latency: got %0d, want 2", n);
        end
        checks++;
        if (wc !== 1 || wv !== 4'b0011 || rc !== 0 || cc !== 0) begin
            errors++;
            $display("FAIL dwrite_strobe: wen_cycles=%0d wen=%b ren=%0d cfg=%0d, want 1 0011 0 0",
                     wc, wv, rc, cc);
        end
        e = sbq.pop_front();
        checks++;
        if (n < 0 || wd !== e.is_d) begin
            errors++; $display("FAIL dwrite_accept: who=%b, want %b", wd, e.is_d);
        end
    endtask

    task automatic test_dcache_read();
        dc_start(32'h8000_0010, 1'b1, 4'b0000, 32'd0);
        sbq.push_back('{1'b1, 1'b1, {32'd0, 32'hA5A5_5678}});
        wait_acc(n, wd, rc, wc, cc, wv, cv, ra);
        dc_stop();
        checks++;
        if (n !== 3 || rc !== 1 || wc !== 0) begin
            errors++;
            $display("FAIL dread_timing: lat=%0d ren=%0d wen=%0d, want 3 1 0", n, rc, wc);
        end
        e = sbq.pop_front();
        checks++;
        if (n < 0 || wd !== e.is_d || dc_rdata !== e.data[31:0]) begin
            errors++;
            $display("FAIL dread_data: who=%b data=%h, want who=%b data=%h",
                     wd, dc_rdata, e.is_d, e.data[31:0]);
        end
    endtask

    task automatic test_rw_priority();
        dc_start(32'h8000_0014, 1'b1, 4'b1111, 32'hCAFE_F00D);
        sbq.push_back('{1'b1, 1'b0, 64'd0});
        wait_acc(n, wd, rc, wc, cc, wv, cv, ra);
        dc_stop();
        e = sbq.pop_front();
        checks++;
        if (n !== 2 || wc !== 1 || rc !== 0 || wd !== e.is_d) begin
            errors++;
            $display("FAIL write_wins: lat=%0d wen=%0d ren=%0d, want 2 1 0", n, wc, rc);
        end
        dc_start(32'h8000_0014, 1'b0, 4'b0000, 32'd0);
        sbq.push_back('{1'b1, 1'b1, {32'd0, 32'hCAFE_F00D}});
        wait_acc(n, wd, rc, wc, cc, wv, cv, ra);
        dc_stop();
        e = sbq.pop_front();
        checks++;
        if (n !== 3 || rc !== 1 || wd !== e.is_d || dc_rdata !== e.data[31:0]) begin
            errors++;
            $display("FAIL no_strobe_read: lat=%0d ren=%0d data=%h, want 3 1 %h",
                     n, rc, dc_rdata, e.data[31:0]);
        end
    endtask

    task automatic test_uart();
        dc_start(32'hC000_0004, 1'b0, 4'b1111, 32'h0000_0055);
        sbq.push_back('{1'b1, 1'b0, 64'd0});
        wait_acc(n, wd, rc, wc, cc, wv, cv, ra);
        dc_stop();
        e = sbq.pop_front();
        checks++;
        if (n !== 2 || cc !== 1 || wc !== 0 || rc !== 0 || wd !== e.is_d) begin
            errors++;
            $display("FAIL uart_write: lat=%0d cfg=%0d wen=%0d ren=%0d, want 2 1 0 0",
                     n, cc, wc, rc);
        end
        checks++;
        if (cv !== 32'h55 || uart_addr !== 32'hC000_0004) begin
            errors++;
            $display("FAIL uart_write_data: data=%h addr=%h, want 00000055 c0000004",
                     cv, uart_addr);
        end
        dc_start(32'hC000_0008, 1'b1, 4'b0000, 32'd0);
        sbq.push_back('{1'b1, 1'b1, {32'd0, 32'h5AA5_0008}});
        wait_acc(n, wd, rc, wc, cc, wv, cv, ra);
        dc_stop();
        e = sbq.pop_front();
        checks++;
        if (n !== 2 || rc !== 0 || cc !== 0 || wd !== e.is_d || dc_rdata !== e.data[31:0]) begin
            errors++;
            $display("FAIL uart_read: lat=%0d ren=%0d data=%h, want 2 0 %h",
                     n, rc, dc_rdata, e.data[31:0]);
        end
        checks++;
        if (rom_raddr !== 32'h40 || ram_addr !== 32'h8000_0014) begin
            errors++;
            $display("FAIL addr_hold: rom=%h ram=%h, want 00000040 80000014",
                     rom_raddr, ram_addr);
        end
    endtask

    task automatic test_ml4();
        int lat;
        int rens;
        lat = -1;
        rens = 0;
        @(posedge clk); #1;
        dc_addr4 = 32'h8000_0030; dc_ren4 = 1'b1; dc_wen4 = 4'b0; dc_req4 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ram_ren4) rens++;
            if (dc_acc4) begin lat = i; break; end
        end
        @(posedge clk); #1 dc_req4 = 1'b0;
        checks++;
        if (lat !== 6 || rens !== 1) begin
            errors++;
            $display("FAIL ml4_timing: lat=%0d ren=%0d, want 6 1", lat, rens);
        end
        checks++;
        if (dc_rdata4 !== 32'h4444_0030) begin
            errors++; $display("FAIL ml4_data: got %h, want 44440030", dc_rdata4);
        end
    endtask

    task automatic test_reset_abort();
        int accs;
        accs = 0;
        dc_start(32'h8000_0018, 1'b0, 4'b1111, 32'h0BAD_0BAD);
        @(posedge clk); #2;
        checks++;
        if (ram_wen !== 4'b1111) begin
            errors++; $display("FAIL abort_issue: ram_wen=%b, want 1111", ram_wen);
        end
        srst_n = 1'b0;
        #1;
        checks++;
        if (ram_wen !== 4'b0 || ram_ren !== 1'b0) begin
            errors++; $display("FAIL abort_strobe: ram_wen=%b ren=%b, want 0", ram_wen, ram_ren);
        end
        dc_req = 1'b0; dc_wen = 4'b0;
        repeat (2) @(posedge clk);
        #1 srst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ic_acc || dc_acc) accs++;
        end
        checks++;
        if (accs !== 0) begin
            errors++; $display("FAIL abort_no_accept: got %0d accepts, want 0", accs);
        end
        dc_start(32'h8000_001C, 1'b0, 4'b0001, 32'h0000_00EE);
        sbq.push_back('{1'b1, 1'b0, 64'd0});
        wait_acc(n, wd, rc, wc, cc, wv, cv, ra);
        dc_stop();
        e = sbq.pop_front();
        checks++;
        if (n !== 2 || wc !== 1 || wd !== e.is_d) begin
            errors++;
            $display("FAIL abort_recover: lat=%0d wen=%0d, want 2 1", n, wc);
        end
    endtask

    task automatic test_contention();
        srst_n = 1'b0;
        ic_raddr = 32'h0000_0100;
        dc_addr = 32'h8000_0020; dc_ren = 1'b1; dc_wen = 4'b0;
        ic_req = 1'b1; dc_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) sbq.push_back('{1'b0, 1'b1, {~32'h100, 32'h100}});
            else sbq.push_back('{1'b1, 1'b1, {32'd0, 32'hA5A5_0008}});
        end
        repeat (2) @(posedge clk);
        #1 srst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_acc(n, wd, rc, wc, cc, wv, cv, ra);
            e = sbq.pop_front();
            checks++;
            if (n < 0) begin
                errors++;
                $display("FAIL contention_timeout: txn %0d no accept, want who=%b", k, e.is_d);
                break;
            end
            if (wd !== e.is_d ||
                (!e.is_d && ic_rdata !== e.data) ||
                (e.is_d && dc_rdata !== e.data[31:0])) begin
                errors++;
                $display("FAIL contention_%0d: who=%b idata=%h ddata=%h, want who=%b data=%h",
                         k, wd, ic_rdata, dc_rdata, e.is_d, e.data);
            end
        end
        @(posedge clk); #1;
        ic_req = 1'b0; dc_req = 1'b0; dc_ren = 1'b0;
        sbq.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        srst_n = 1'b0;
        ic_req = 1'b0; ic_raddr = 32'd0;
        dc_req = 1'b0; dc_ren = 1'b0; dc_wen = 4'b0;
        dc_addr = 32'd0; dc_wdata = 32'd0;
        ic_req4 = 1'b0; ic_raddr4 = 32'd0;
        dc_req4 = 1'b0; dc_ren4 = 1'b0; dc_wen4 = 4'b0;
        dc_addr4 = 32'd0; dc_wdata4 = 32'd0;
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_dcache_read();
        test_rw_priority();
        test_uart();
        test_ml4();
        test_reset_abort();
        test_contention();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
